bin2bcd_seq: RTL

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the 6-digit seven-segment scanner and drives that block's 24-bit BCD `dispdata` input. The calculator datapath presents a binary result plus a start pulse. The block returns packed BCD digits, held stable until the next conversion completes, and an overflow flag.

---
 rtl/bin2bcd_if.sv | 32 +++
 rtl/bin2bcd_seq.sv | 91 +++++++++
 2 files changed

// File: rtl/bin2bcd_if.sv
// Request/result bundle between the calculator datapath and the binary-to-BCD converter.
interface bin2bcd_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  done;
    logic                  busy;
    logic                  ovf;

    // Datapath side: issues requests, consumes results.
    modport master (
        output start,
        output bin,
        input  bcd,
        input  done,
        input  busy,
        input  ovf
    );

    // Converter side.
    modport slave (
        input  start,
        input  bin,
        output bcd,
        output done,
        output busy,
        output ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the seven-segment scanner.
// Results are registered and only change when a conversion completes, so the display
// never shows a partially converted value. Values above the displayable range
// saturate to all nines and raise ovf.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6,
    parameter int CNT_W  = 5
) (
    input  logic       clk,
    input  logic       rst,
    bin2bcd_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;

    // Largest value that fits in DIGITS decimal digits.
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10 ** DIGITS - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] sr;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic             too_big;

    // Add-3 correction on every accumulator nibble that is 5 or more; the binary
    // remainder is never corrected.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sr       <= '0;
            acc      <= '0;
            too_big  <= 1'b0;
            bus.bcd  <= '0;
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        sr       <= bus.bin;
                        acc      <= '0;
                        cnt      <= '0;
                        too_big  <= (bus.bin > MAX_VAL);
                        bus.busy <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Overflowing values may lose accumulator MSBs here; they are
                    // replaced by all nines at completion anyway.
                    {acc, sr} <= {acc_adj, sr} << 1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        bus.busy <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.bcd  <= too_big ? ALL_NINES : acc;
                    bus.ovf  <= too_big;
                    bus.done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
